// File: rtl/nonce_arbiter.sv
// rtl/nonce_arbiter.sv - per-core golden-nonce capture, round-robin arbiter and show-ahead output FIFO
module nonce_arbiter #(
  parameter int CORE_BITS = 2,
  parameter int FIFO_BITS = 2,
  localparam int NUM_CORES = 2**CORE_BITS,
  localparam int FIFO_DEPTH = 2**FIFO_BITS
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_CORES-1:0]      core_match,
  input  logic [32*NUM_CORES-1:0]   core_nonce,
  input  logic                      flush,
  output logic                      out_valid,
  output logic [31:0]               out_nonce,
  output logic [CORE_BITS-1:0]      out_core,
  input  logic                      out_ready,
  output logic [FIFO_BITS:0]        fifo_level,
  output logic [7:0]                drop_count
);

  localparam int ENTRY_W = CORE_BITS + 32;

  logic [NUM_CORES-1:0] pend;
  logic [31:0]          hold [NUM_CORES];
  logic [CORE_BITS-1:0] last;

  logic [ENTRY_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [FIFO_BITS-1:0] wr_ptr;
  logic [FIFO_BITS-1:0] rd_ptr;
  logic [FIFO_BITS:0]   level_next;
  logic [ENTRY_W-1:0]   head;

  logic                 full;
  logic                 pop;
  logic                 grant_any;
  logic [CORE_BITS-1:0] grant_idx;
  logic [CORE_BITS-1:0] cand;
  logic                 do_grant;
  logic [NUM_CORES-1:0] gnt_vec;
  logic [NUM_CORES-1:0] drop_vec;
  logic [15:0]          drop_num;
  logic [15:0]          drop_sum;

  assign full = (fifo_level == (FIFO_BITS+1)'(FIFO_DEPTH));
  assign pop  = out_valid & out_ready & ~flush;

  // Scan starts one past the last winner so every pending core is served within NUM_CORES grants.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      cand = last + CORE_BITS'(k);
      if (!grant_any && pend[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign do_grant = grant_any & (~full | pop) & ~flush;
  assign gnt_vec  = do_grant ? (NUM_CORES'(1) << grant_idx) : '0;
  assign drop_vec = core_match & pend & ~gnt_vec & {NUM_CORES{~flush}};

  always_comb begin
    drop_num = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      drop_num = drop_num + 16'(drop_vec[i]);
    end
    drop_sum = 16'(drop_count) + drop_num;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        hold[i] <= '0;
      end
    end else if (flush) begin
      pend <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (core_match[i] && (!pend[i] || gnt_vec[i])) begin
          pend[i] <= 1'b1;
          hold[i] <= core_nonce[32*i +: 32];
        end else if (gnt_vec[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last       <= '1;
      drop_count <= '0;
    end else begin
      if (do_grant) begin
        last <= grant_idx;
      end
      drop_count <= (drop_sum > 16'd255) ? 8'd255 : drop_sum[7:0];
    end
  end

  always_comb begin
    level_next = fifo_level;
    if (do_grant && !pop) begin
      level_next = fifo_level + 1'b1;
    end else if (pop && !do_grant) begin
      level_next = fifo_level - 1'b1;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_grant) begin
      fifo_mem[wr_ptr] <= {grant_idx, hold[grant_idx]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      out_valid  <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      out_valid  <= 1'b0;
    end else begin
      if (do_grant) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      fifo_level <= level_next;
      out_valid  <= (level_next != '0);
    end
  end

  assign head      = fifo_mem[rd_ptr];
  assign out_nonce = out_valid ? head[31:0] : '0;
  assign out_core  = out_valid ? head[32 +: CORE_BITS] : '0;

endmodule

// File: tb/tb_nonce_arbiter.sv
// tb/tb_nonce_arbiter.sv - scoreboard bench for nonce_arbiter
module tb_nonce_arbiter;

  logic         clk;
  logic         reset_n;
  logic [3:0]   core_match;
  logic [127:0] core_nonce;
  logic         flush;
  logic         out_valid;
  logic [31:0]  out_nonce;
  logic [1:0]   out_core;
  logic         out_ready;
  logic [2:0]   fifo_level;
  logic [7:0]   drop_count;

  typedef struct {
    logic [1:0]  core;
    logic [31:0] nonce;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  nonce_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .core_match (core_match),
    .core_nonce (core_nonce),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_nonce  (out_nonce),
    .out_core   (out_core),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    core_match = '0;
    flush = 1'b0;
    out_ready = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    sb.delete();
  endtask

  // All four cores report together; expectations queued in round-robin order starting at core 0.
  task automatic burst_all(input logic [31:0] base);
    for (int i = 0; i < 4; i++) begin
      core_nonce[32*i +: 32] = base + 32'(i);
      sb.push_back('{core: 2'(i), nonce: base + 32'(i)});
    end
    core_match = 4'hF;
    tick();
    core_match = '0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    core_match = '0;
    core_nonce = '0;
    flush = 1'b0;
    out_ready = 1'b0;
    repeat (2) tick();
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0 || drop_count !== 8'd0 ||
        out_nonce !== 32'd0 || out_core !== 2'd0)
      $display("FAIL reset_state: got v=%b lvl=%0d drop=%0d nonce=%h core=%0d expected all zero",
               out_valid, fifo_level, drop_count, out_nonce, out_core);
    else passed++;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    core_nonce[64 +: 32] = 32'hDEADBEEF;
    core_match = 4'b0100;
    tick();
    core_match = '0;
    checks++;
    if (out_valid !== 1'b0)
      $display("FAIL single_early: got out_valid=%b expected 0", out_valid);
    else passed++;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_nonce !== 32'hDEADBEEF || out_core !== 2'd2)
      $display("FAIL single_head: got v=%b nonce=%h core=%0d expected v=1 nonce=deadbeef core=2",
               out_valid, out_nonce, out_core);
    else passed++;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0)
      $display("FAIL single_pop: got v=%b lvl=%0d expected v=0 lvl=0", out_valid, fifo_level);
    else passed++;
  endtask

  task automatic test_simultaneous();
    exp_t e;
    apply_reset();
    for (int b = 0; b < 2; b++) begin
      burst_all(32'h100 + 32'(b) * 32'h100);
      checks++;
      if (fifo_level !== 3'd4)
        $display("FAIL simul_level: got %0d expected 4", fifo_level);
      else passed++;
      out_ready = 1'b1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_core !== e.core || out_nonce !== e.nonce)
          $display("FAIL simul_order: got v=%b core=%0d nonce=%h expected v=1 core=%0d nonce=%h",
                   out_valid, out_core, out_nonce, e.core, e.nonce);
        else passed++;
        tick();
      end
      out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    apply_reset();
    burst_all(32'h100);
    for (int k = 0; k < 3; k++) begin
      core_nonce[32 +: 32] = 32'hA1 + 32'(k);
      core_match = 4'b0010;
      tick();
    end
    core_match = '0;
    sb.push_back('{core: 2'd1, nonce: 32'hA1});
    checks++;
    if (drop_count !== 8'd2 || fifo_level !== 3'd4)
      $display("FAIL drop_two: got drop=%0d lvl=%0d expected drop=2 lvl=4", drop_count, fifo_level);
    else passed++;
    core_nonce[32 +: 32] = 32'hBB;
    core_match = 4'b0010;
    repeat (300) tick();
    core_match = '0;
    checks++;
    if (drop_count !== 8'd255)
      $display("FAIL drop_saturate: got %0d expected 255", drop_count);
    else passed++;
    out_ready = 1'b1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_core !== e.core || out_nonce !== e.nonce)
        $display("FAIL bp_order: got v=%b core=%0d nonce=%h expected v=1 core=%0d nonce=%h",
                 out_valid, out_core, out_nonce, e.core, e.nonce);
      else passed++;
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (fifo_level !== 3'd0 || out_valid !== 1'b0 || drop_count !== 8'd255)
      $display("FAIL bp_empty: got lvl=%0d v=%b drop=%0d expected lvl=0 v=0 drop=255",
               fifo_level, out_valid, drop_count);
    else passed++;
  endtask

  task automatic test_full_push_pop();
    exp_t e;
    apply_reset();
    burst_all(32'h300);
    core_nonce[31:0] = 32'h3FF;
    core_match = 4'b0001;
    tick();
    core_match = '0;
    sb.push_back('{core: 2'd0, nonce: 32'h3FF});
    checks++;
    if (fifo_level !== 3'd4)
      $display("FAIL full_before: got lvl=%0d expected 4", fifo_level);
    else passed++;
    out_ready = 1'b1;
    e = sb.pop_front();
    checks++;
    if (out_core !== e.core || out_nonce !== e.nonce)
      $display("FAIL full_head: got core=%0d nonce=%h expected core=%0d nonce=%h",
               out_core, out_nonce, e.core, e.nonce);
    else passed++;
    tick();
    checks++;
    if (fifo_level !== 3'd4)
      $display("FAIL full_push_pop: got lvl=%0d expected 4", fifo_level);
    else passed++;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_core !== e.core || out_nonce !== e.nonce)
        $display("FAIL full_order: got v=%b core=%0d nonce=%h expected v=1 core=%0d nonce=%h",
                 out_valid, out_core, out_nonce, e.core, e.nonce);
      else passed++;
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    apply_reset();
    for (int i = 0; i < 4; i++) core_nonce[32*i +: 32] = 32'h500 + 32'(i);
    core_match = 4'b0111;
    tick();
    core_match = '0;
    repeat (3) tick();
    core_match = 4'b1000;
    tick();
    checks++;
    if (fifo_level !== 3'd3)
      $display("FAIL flush_pre: got lvl=%0d expected 3", fifo_level);
    else passed++;
    flush = 1'b1;
    core_match = 4'b1010;
    tick();
    flush = 1'b0;
    core_match = '0;
    checks++;
    if (fifo_level !== 3'd0 || out_valid !== 1'b0 || drop_count !== 8'd0)
      $display("FAIL flush_now: got lvl=%0d v=%b drop=%0d expected 0 0 0",
               fifo_level, out_valid, drop_count);
    else passed++;
    repeat (4) tick();
    checks++;
    if (fifo_level !== 3'd0 || out_valid !== 1'b0)
      $display("FAIL flush_pend: got lvl=%0d v=%b expected lvl=0 v=0", fifo_level, out_valid);
    else passed++;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    apply_reset();
    core_nonce[31:0]  = 32'h700;
    core_nonce[63:32] = 32'h701;
    core_match = 4'b0011;
    tick();
    core_match = '0;
    repeat (2) tick();
    checks++;
    if (fifo_level !== 3'd2)
      $display("FAIL mid_pre: got lvl=%0d expected 2", fifo_level);
    else passed++;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0 || out_nonce !== 32'd0 || out_core !== 2'd0)
      $display("FAIL mid_async: got v=%b lvl=%0d nonce=%h core=%0d expected all zero",
               out_valid, fifo_level, out_nonce, out_core);
    else passed++;
    tick();
    reset_n = 1'b1;
    tick();
    core_nonce[31:0] = 32'h7AA;
    core_match = 4'b0001;
    sb.push_back('{core: 2'd0, nonce: 32'h7AA});
    tick();
    core_match = '0;
    checks++;
    if (out_valid !== 1'b0)
      $display("FAIL mid_latency: got out_valid=%b expected 0 one cycle after match", out_valid);
    else passed++;
    tick();
    out_ready = 1'b1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_core !== e.core || out_nonce !== e.nonce)
        $display("FAIL mid_after: got v=%b core=%0d nonce=%h expected v=1 core=%0d nonce=%h",
                 out_valid, out_core, out_nonce, e.core, e.nonce);
      else passed++;
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0)
      $display("FAIL mid_drained: got v=%b lvl=%0d expected 0 0", out_valid, fifo_level);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_full_push_pop();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/nonce_arbiter.md
# nonce_arbiter

Collects golden-nonce reports from `NUM_CORES` hashcore instances and serialises them into one ordered stream toward the host output buffer. Each hashcore's one-cycle `golden_nonce_match` report is captured in a per-core holding slot. A round-robin arbiter then moves one slot per cycle into a show-ahead FIFO, which the host interface drains with a valid/ready handshake. The block sits between the hashcore array and the outbuf loader in the multi-core top level. It flushes stale results when new work is loaded.

## Interface
Parameters:
- `CORE_BITS`, default 2: core index width; `NUM_CORES = 2**CORE_BITS`.
- `FIFO_BITS`, default 2: FIFO address width; `FIFO_DEPTH = 2**FIFO_BITS`.

Ports:
- `clk`  in  1: the only clock, the hash clock; all logic is on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `core_match`  in  NUM_CORES: bit i is the one-cycle golden_nonce_match pulse from core i.
- `core_nonce`  in  32*NUM_CORES: bits [32i+31:32i] carry core i's golden nonce, valid while `core_match[i]` is 1.
- `flush`  in  1: one-cycle pulse on new work load; discards all pending and queued nonces.
- `out_valid`  out  1: the FIFO head is valid.
- `out_nonce`  out  32: FIFO head nonce.
- `out_core`  out  CORE_BITS: index of the core that produced the head nonce.
- `out_ready`  in  1: consumer accepts the head when `out_valid & out_ready`.
- `fifo_level`  out  FIFO_BITS+1: number of queued entries, 0..FIFO_DEPTH.
- `drop_count`  out  8: saturating count of lost reports.

## Operation
- **Reset** (`reset_n` = 0, asynchronous, any cycle): all pending bits 0, FIFO empty, `out_valid` 0, `out_nonce` 0, `out_core` 0, `fifo_level` 0, `drop_count` 0, round-robin pointer `last` = NUM_CORES-1 so core 0 has first priority. Asserting reset mid-operation discards everything with no partial state retained.
- **Capture**, per core i, each edge:
  - `core_match[i]` and slot empty, or slot being granted this edge: set `pend[i]` to 1 and load `hold[i]` with the nonce.
  - `core_match[i]` and slot pending and not granted: the new report is dropped, the old one is kept, and the loss counts toward `drop_count`.
- **Arbitration**, each edge:
  - Condition: any `pend` set, and the FIFO is either not full or popping this edge.
  - Grant goes to the first pending index scanning `last+1, last+2, …` modulo NUM_CORES.
  - The grant pushes `{index, hold[index]}`, clears that pend bit (unless a same-edge re-capture applies) and sets `last` to the granted index.
  - At most one grant per cycle.
- **FIFO**: show-ahead, so the head is always on `out_nonce`/`out_core` while `out_valid` is 1.
  - Push and pop on the same edge is legal at any level, including full; the level is unchanged.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- **Drop counter**: each edge it adds the number of cores dropped that edge (popcount) and saturates at 255. It is cleared only by reset, not by flush.
- **Flush**: on the edge where `flush` is 1:
  - pend bits cleared and FIFO emptied;
  - `core_match` arriving on that same edge is discarded and not counted as a drop;
  - `last` is unchanged.
  - Flush takes priority over push, pop and capture.

## Timing
- `core_match[i]` high in cycle t gives `pend[i]` = 1 after edge t.
- Grant earliest at edge t+1, so `out_valid` = 1 after edge t+1: 2-cycle latency when no other core is pending and the FIFO is not full.
- Throughput: one nonce per cycle in and out.
- All reports pending simultaneously are granted on consecutive edges in round-robin order.
- `fifo_level` and `out_valid` are registered and update on the same edge as the push or pop.
- Consumer handshake:
  - `out_valid` stays high and the head stays stable until accepted.
  - `out_ready` may be held high permanently.
  - There is no combinational path from `out_ready` to `out_valid`.

## Test plan
- Single report: core 2 matches with 0xDEADBEEF at cycle 10 → `out_valid` 1 from cycle 12, `out_nonce` 0xDEADBEEF, `out_core` 2; `out_ready` 1 at cycle 12 → `fifo_level` 0 and `out_valid` 0 at cycle 13.
- Simultaneous reports: all 4 cores match at once with nonces 0x100+i, `out_ready` 0 → after 4 grants `fifo_level` = 4, and pops return cores 0, 1, 2, 3 in that order. A second burst after the last grant (core 3) also returns 0, 1, 2, 3.
- Backpressure and drops: `out_ready` 0, FIFO filled to 4, then core 1 matches three times → pend holds the first of those nonces, `drop_count` = 2. Then `out_ready` 1 → the held nonce appears after the 4 queued entries. 300 forced drops → `drop_count` = 255.
- Full with same-edge push and pop: FIFO full, core 0 pending, `out_ready` 1 → grant occurs and `fifo_level` stays 4.
- Flush: 3 entries queued and core 3 pending, with `flush` and a `core_match[1]` on the same edge → `fifo_level` 0, `out_valid` 0, no pend bits set, `drop_count` unchanged.
- Reset mid-burst: `reset_n` low asynchronously between edges while 2 entries are queued → outputs zero immediately. After release, a core 0 match produces `out_valid` 2 cycles later.
